// File: rtl/job_control_pkg.sv
// Shared constants and types for the AFU job-control sequencer.
package job_control_pkg;

  localparam logic [7:0] JCOM_RESET = 8'h80;
  localparam logic [7:0] JCOM_START = 8'h90;
  localparam logic [7:0] JCOM_LLCMD = 8'h45;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    RUNNING,
    DONE
  } state_t;

  localparam logic [63:0] ERR_JCOM_PAR = 64'd1;
  localparam logic [63:0] ERR_JEA_PAR  = 64'd2;
  localparam logic [63:0] ERR_AFU_BASE = 64'h100;

endpackage

// File: rtl/odd_parity_check.sv
// Odd-parity checker: ok is high when the field plus its parity bit XOR to 1.
module odd_parity_check #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_par,
  output logic             ok
);

  assign ok = ^{i_data, i_par};

endmodule

// File: rtl/job_control.sv
// AFU job-control sequencer: decodes PSL job commands, checks parity,
// drives datapath reset/start and reports done/error/ack to the host.
module job_control
  import job_control_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic        ha_pclock,
  input  logic        reset,
  input  logic        ha_jval,
  input  logic [0:7]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [0:63] ha_jea,
  input  logic        ha_jeapar,
  input  logic        afu_done,
  input  logic        afu_error,
  input  logic [0:7]  afu_error_code,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic [0:63] ah_jerror,
  output logic        ah_jyield,
  output logic        afu_reset,
  output logic        afu_start,
  output logic [0:63] afu_wed
);

  localparam logic [7:0] RST_LOAD = 8'(RESET_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt;
  logic [63:0] r_err;
  logic [63:0] w_err;
  logic [0:63] w_wed;
  logic [0:63] w_jerror;
  logic        w_jdone;
  logic        w_jcack;
  logic        w_afu_reset;
  logic        w_afu_start;

  logic w_com_ok;
  logic w_jea_ok;
  logic w_com_good;
  logic w_jea_good;
  logic w_cmd_ok;
  logic w_cmd_bad;
  logic w_is_reset;
  logic w_is_start;
  logic w_is_llcmd;

  odd_parity_check #(.WIDTH(8)) u_com_par (
    .i_data (ha_jcom),
    .i_par  (ha_jcompar),
    .ok     (w_com_ok)
  );

  odd_parity_check #(.WIDTH(64)) u_jea_par (
    .i_data (ha_jea),
    .i_par  (ha_jeapar),
    .ok     (w_jea_ok)
  );

  assign w_com_good = !PARITY_EN || w_com_ok;
  assign w_jea_good = !PARITY_EN || w_jea_ok;
  assign w_cmd_ok   = ha_jval && w_com_good;
  assign w_cmd_bad  = ha_jval && !w_com_good;
  assign w_is_reset = w_cmd_ok && (ha_jcom == JCOM_RESET);
  assign w_is_start = w_cmd_ok && (ha_jcom == JCOM_START);
  assign w_is_llcmd = w_cmd_ok && (ha_jcom == JCOM_LLCMD);

  assign ah_jyield = 1'b0;

  // State register.
  always_ff @(posedge ha_pclock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode. DONE is the single cycle in which ah_jdone is high;
  // it accepts a clean START but suppresses anything that would raise
  // another jdone, so jdone can never be high on consecutive cycles.
  always_comb begin
    w_next = r_state;
    if (w_is_reset) begin
      w_next = RST;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_cmd_bad)       w_next = DONE;
          else if (w_is_start) w_next = w_jea_good ? RUNNING : DONE;
        end
        DONE: begin
          w_next = (w_is_start && w_jea_good) ? RUNNING : IDLE;
        end
        RUNNING: begin
          if (w_cmd_bad)                  w_next = RST;
          else if (afu_error || afu_done) w_next = DONE;
        end
        RST: begin
          if (r_cnt <= 8'd1) w_next = DONE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, counter, latched error and WED.
  always_comb begin
    w_jdone     = 1'b0;
    w_jerror    = '0;
    w_afu_reset = 1'b0;
    w_afu_start = 1'b0;
    w_jcack     = w_is_llcmd;
    w_cnt       = r_cnt;
    w_err       = r_err;
    w_wed       = afu_wed;
    if (w_is_reset) begin
      w_afu_reset = 1'b1;
      w_cnt       = RST_LOAD;
      w_err       = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_cmd_bad) begin
            w_jdone  = 1'b1;
            w_jerror = ERR_JCOM_PAR;
          end else if (w_is_start) begin
            if (w_jea_good) begin
              w_wed       = ha_jea;
              w_afu_start = 1'b1;
            end else begin
              w_jdone  = 1'b1;
              w_jerror = ERR_JEA_PAR;
            end
          end
        end
        DONE: begin
          if (w_is_start && w_jea_good) begin
            w_wed       = ha_jea;
            w_afu_start = 1'b1;
          end
        end
        RUNNING: begin
          if (w_cmd_bad) begin
            w_afu_reset = 1'b1;
            w_cnt       = RST_LOAD;
            w_err       = ERR_JCOM_PAR;
          end else if (afu_error) begin
            w_jdone  = 1'b1;
            w_jerror = ERR_AFU_BASE | {56'd0, afu_error_code};
          end else if (afu_done) begin
            w_jdone = 1'b1;
          end
        end
        RST: begin
          if (r_cnt <= 8'd1) begin
            w_jdone  = 1'b1;
            w_jerror = r_err;
            w_cnt    = '0;
          end else begin
            w_afu_reset = 1'b1;
            w_cnt       = r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath register bank.
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      ah_jrunning <= 1'b0;
      ah_jdone    <= 1'b0;
      ah_jcack    <= 1'b0;
      ah_jerror   <= '0;
      afu_reset   <= 1'b0;
      afu_start   <= 1'b0;
      afu_wed     <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
    end else begin
      ah_jrunning <= (w_next == RUNNING);
      ah_jdone    <= w_jdone;
      ah_jcack    <= w_jcack;
      ah_jerror   <= w_jerror;
      afu_reset   <= w_afu_reset;
      afu_start   <= w_afu_start;
      afu_wed     <= w_wed;
      r_cnt       <= w_cnt;
      r_err       <= w_err;
    end
  end

endmodule

// File: doc/job_control.md
Name: job_control

Overview:
Sequences the AFU job-control interface: decodes ha_jval/ha_jcom, checks command and address parity, generates the datapath reset and start pulses, and tracks the run state. It reports completion to the host via ah_jrunning, ah_jdone, ah_jerror and ah_jcack. Sits between the PSL control interface and the AFU datapath, replacing ad-hoc job handling in the AFU top level.

Parameters:
RESET_CYCLES, 4, cycles afu_reset is held high for a reset command (legal range 1..255)
PARITY_EN, 1, 1 = check ha_jcompar/ha_jeapar; 0 = parity ignored

Ports:
ha_pclock  in  1  clock
reset  in  1  synchronous active-high reset
ha_jval  in  1  job command valid
ha_jcom  in  [0:7]  job command
ha_jcompar  in  1  odd parity over ha_jcom
ha_jea  in  [0:63]  job effective address (WED pointer)
ha_jeapar  in  1  odd parity over ha_jea
afu_done  in  1  datapath finished (level or pulse, sampled only in RUNNING)
afu_error  in  1  datapath fatal error (sampled only in RUNNING)
afu_error_code  in  [0:7]  error detail, valid with afu_error
ah_jrunning  out  1  job running
ah_jdone  out  1  one-cycle done pulse
ah_jcack  out  1  one-cycle LLCMD acknowledge
ah_jerror  out  [0:63]  error code, non-zero only in the ah_jdone cycle
ah_jyield  out  1  tied 0
afu_reset  out  1  reset to datapath
afu_start  out  1  one-cycle start pulse to datapath
afu_wed  out  [0:63]  WED address latched on accepted start

Behaviour:
- All outputs registered. On reset: state IDLE, every output 0, afu_wed 0, reset counter 0.
- Commands: RESET 0x80, START 0x90, LLCMD 0x45. All other codes are ignored with no response.
- Parity, when PARITY_EN=1: parity is good when the XOR of the field and its parity bit is 1.
- States: IDLE, RST, RUNNING, DONE.
- RESET accepted in any state (cycle t). Goes to RST.
  - ah_jrunning = 0 at t+1.
  - afu_reset = 1 for cycles t+1..t+RESET_CYCLES.
  - ah_jdone = 1 at t+RESET_CYCLES+1 with the latched error code (0 for a normal reset), then IDLE.
  - A RESET received while in RST restarts the counter. No extra jdone is produced.
- START in IDLE (cycle t):
  - ha_jea parity good: afu_wed <= ha_jea; at t+1 afu_start = 1 (one cycle) and ah_jrunning = 1; go to RUNNING.
  - ha_jea parity bad: no start, afu_wed unchanged; ah_jdone = 1 at t+1 with ah_jerror = 2.
- START while in RST or RUNNING: ignored.
- LLCMD in any state: ah_jcack = 1 at t+1 for one cycle. State is unaffected.
- ha_jcom parity error (any command code):
  - Command discarded.
  - In RUNNING: error code 1 is latched and the block enters RST (full reset sequence); the jdone pulse carries ah_jerror = 1.
  - In IDLE: ah_jdone at t+1 with ah_jerror = 1.
- RUNNING, cycle t:
  - afu_error: ah_jdone = 1 and ah_jrunning = 0 at t+1; ah_jerror = 64'h100 | afu_error_code.
  - afu_done without afu_error: same timing, ah_jerror = 0.
  - Next state IDLE.
- Priority within one cycle: reset > RESET command > jcom parity error > afu_error > afu_done > START/LLCMD.
- LLCMD coincident with an RST/DONE transition is still acknowledged.
- ah_jerror is 0 in every cycle where ah_jdone = 0.
- ah_jdone and afu_start are never high for two consecutive cycles.

Decomposition:
- Package job_control_pkg holds:
  - JCOM_RESET, JCOM_START, JCOM_LLCMD constants.
  - State enum (IDLE, RST, RUNNING, DONE).
  - Error constants: ERR_JCOM_PAR = 1, ERR_JEA_PAR = 2, ERR_AFU_BASE = 64'h100.
- One sub-module: odd_parity_check, parameter WIDTH, output ok. Instantiated twice (8-bit command, 64-bit address).

Test Plan:
- reset high 2 cycles, then RESET 0x80 with good parity -> afu_reset high exactly 4 cycles, ah_jdone single pulse at t+5, ah_jerror 0.
- START 0x90, ha_jea = 64'h0000_1000_0000_0080 good parity -> at t+1 afu_start pulse, ah_jrunning 1, afu_wed = that address. afu_done at t+10 -> ah_jdone at t+11, ah_jrunning 0.
- START with bad ha_jeapar -> no afu_start, ah_jdone at t+1 with ah_jerror = 2. Second START with good parity then succeeds.
- RUNNING with afu_error = 1, afu_error_code = 8'h3C and afu_done in the same cycle -> ah_jdone with ah_jerror = 64'h13C.
- RUNNING, RESET command coincident with afu_done -> RESET wins: ah_jrunning 0 at t+1, afu_reset 4 cycles, one jdone with ah_jerror 0.
- LLCMD 0x45 during RUNNING, plus a bad-parity command during RUNNING -> ah_jcack pulse at t+1 with run continuing. Bad parity causes reset sequence then jdone with ah_jerror = 1.
